pkt_buffer_fl_ctrl: RTL and testbench
=====================================

// Module: pkt_buffer_fl_ctrl
// PURPOSE
//  Free-list controller for the shared packet/meta/PIFO buffer BRAMs (DEPTH slots, one 256b beat per slot).
//  Hands out one free slot address per accepted ingress beat, driving the buffer port-A write enable/address.
//  Takes slot addresses back from the PIFO dequeue side once a beat has been read out through port B.
//  Sits between the ingress datapath and the buffer wrapper; the PIFO stores the returned addresses.
// PARAMETERS
//  ADDR_WIDTH  12    slot address width; also the width of free-list entries
//  DEPTH       4096  number of buffer slots; must equal 2**ADDR_WIDTH
//  LOW_WM      16    almost_empty asserts when free_count <= LOW_WM
// PORTS
//  clk           in   1             clock
//  rstn          in   1             synchronous active-low reset
//  in_valid      in   1             ingress beat available
//  in_ready      out  1             controller can accept a beat (slot available)
//  buf_wr_en     out  1             buffer port-A write enable (= in_valid & in_ready)
//  buf_wr_addr   out  ADDR_WIDTH    slot the current beat is written to; also reported to PIFO
//  rel_valid     in   1             release one slot back to the free list
//  rel_addr      in   ADDR_WIDTH    slot being released
//  init_done     out  1             free list initialised, controller in READY
//  free_count    out  ADDR_WIDTH+1  number of free slots, 0..DEPTH
//  almost_empty  out  1             free_count <= LOW_WM
//  rel_err       out  1             one-cycle pulse: release dropped (INIT state or list full)
// BEHAVIOUR
//  Reset: rstn synchronous, active-low; clock clk. During/after reset: state=INIT, head=tail=0,
//   free_count=0, init_done=0, in_ready=0, buf_wr_en=0, buf_wr_addr=0, rel_err=0, almost_empty=1.
//  Free list: circular FIFO fl_mem[DEPTH] of ADDR_WIDTH entries, async (distributed) read at head,
//   sync write at tail; head/tail are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
//  FSM INIT: first cycle with rstn=1 writes fl_mem[0]=0, next fl_mem[1]=1, ... one per cycle;
//   tail and free_count increment each write. After the write of DEPTH-1 (DEPTH cycles), go READY:
//   head=0, tail=0, free_count=DEPTH, init_done=1. INIT -> READY only; READY -> INIT only via reset.
//  FSM READY: in_ready = (free_count != 0), combinational. buf_wr_addr = fl_mem[head] (0 when not READY).
//   Accept (in_valid & in_ready): buf_wr_en=1 same cycle, head+1 at next edge. Zero-cycle alloc latency.
//  Release in READY: if free_count < DEPTH or an alloc occurs same cycle -> fl_mem[tail]=rel_addr, tail+1.
//   If free_count == DEPTH and no same-cycle alloc -> dropped, rel_err=1 next cycle (registered pulse).
//  Release in INIT: dropped, rel_err pulse; no state change.
//  free_count next = free_count - alloc + accepted_release; simultaneous alloc+release leaves it unchanged.
//  Empty: free_count==0 -> in_ready=0; a release that cycle is pushed; in_ready=1 next cycle and
//   buf_wr_addr = released address (no same-cycle bypass).
//  Duplicate/illegal release addresses are not checked; caller guarantees each slot released once.
//  Reset mid-operation: all state discarded, full DEPTH-cycle re-initialisation restarts.
//  almost_empty combinational from free_count; free_count, init_done registered.
// TESTING
//  Reset, rstn=1 for DEPTH cycles -> init_done rises on cycle DEPTH+1, free_count=4096, in_ready=1.
//  After init, 3 beats in_valid=1 -> buf_wr_addr 0,1,2 with buf_wr_en=1; free_count=4093.
//  Drain all 4096 slots -> in_ready=0 at free_count=0; release addr 7 -> next cycle in_ready=1, buf_wr_addr=7.
//  Alloc + release (addr 5) same cycle at free_count=100 -> free_count stays 100; 5 returned after 99 further allocs.
//  Release with free_count=4096 -> rel_err one-cycle pulse, free_count unchanged; release during INIT likewise.
//  Assert rstn=0 mid-traffic at free_count=50 -> outputs to reset values; re-init takes 4096 cycles, alloc restarts at 0.

Source files
------------

// File: rtl/pkt_buffer_fl_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pkt_buffer_fl_ctrl_if
// Brief    : Ingress-allocate / buffer-write / slot-release bundle of the
//            packet buffer free-list controller.
// Revision : 1.0 - initial release
// ============================================================================
interface pkt_buffer_fl_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  buf_wr_en;
    logic [ADDR_WIDTH-1:0] buf_wr_addr;
    logic                  rel_valid;
    logic [ADDR_WIDTH-1:0] rel_addr;

    modport master (
        output in_valid, rel_valid, rel_addr,
        input  in_ready, buf_wr_en, buf_wr_addr
    );

    modport slave (
        input  in_valid, rel_valid, rel_addr,
        output in_ready, buf_wr_en, buf_wr_addr
    );
endinterface
`default_nettype wire

// File: rtl/pkt_buffer_fl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pkt_buffer_fl_ctrl
// Brief    : Circular free list of buffer slot addresses; one slot handed out
//            per accepted ingress beat, slots returned by the dequeue side.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_buffer_fl_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int LOW_WM     = 16
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    pkt_buffer_fl_ctrl_if.slave    fl_if,
    output logic                   init_done,
    output logic [ADDR_WIDTH:0]    free_count,
    output logic                   almost_empty,
    output logic                   rel_err
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_LOW_WM    = (ADDR_WIDTH+1)'(LOW_WM);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_head, w_head_nxt;
    logic [ADDR_WIDTH-1:0] r_tail, w_tail_nxt;
    logic [ADDR_WIDTH:0]   r_free_count, w_free_count_nxt;
    logic                  r_init_done, w_init_done_nxt;
    logic                  r_rel_err, w_rel_err_nxt;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_wdata;
    logic                  w_in_ready;
    logic                  w_alloc;
    logic                  w_rel_acc;

    logic [ADDR_WIDTH-1:0] r_fl_mem [DEPTH];

    always_comb begin
        w_state_nxt      = r_state;
        w_head_nxt       = r_head;
        w_tail_nxt       = r_tail;
        w_free_count_nxt = r_free_count;
        w_init_done_nxt  = r_init_done;
        w_rel_err_nxt    = 1'b0;
        w_mem_we         = 1'b0;
        w_mem_wdata      = r_tail;
        w_in_ready       = 1'b0;
        w_alloc          = 1'b0;
        w_rel_acc        = 1'b0;

        case (r_state)
            ST_INIT: begin
                // Seed slot i with address i; the tail doubles as the seed counter.
                w_mem_we         = 1'b1;
                w_mem_wdata      = r_tail;
                w_tail_nxt       = r_tail + c_ADDR_ONE;
                w_free_count_nxt = r_free_count + c_CNT_ONE;
                w_rel_err_nxt    = fl_if.rel_valid;
                if (r_tail == c_ADDR_LAST) begin
                    w_state_nxt     = ST_READY;
                    w_head_nxt      = '0;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_READY: begin
                w_in_ready    = (r_free_count != '0);
                w_alloc       = fl_if.in_valid & w_in_ready;
                // A same-cycle alloc frees one entry, so a release at full is still legal.
                w_rel_acc     = fl_if.rel_valid & ((r_free_count != c_CNT_FULL) | w_alloc);
                w_rel_err_nxt = fl_if.rel_valid & ~w_rel_acc;
                if (w_alloc) begin
                    w_head_nxt = r_head + c_ADDR_ONE;
                end
                if (w_rel_acc) begin
                    w_mem_we    = 1'b1;
                    w_mem_wdata = fl_if.rel_addr;
                    w_tail_nxt  = r_tail + c_ADDR_ONE;
                end
                case ({w_alloc, w_rel_acc})
                    2'b10:   w_free_count_nxt = r_free_count - c_CNT_ONE;
                    2'b01:   w_free_count_nxt = r_free_count + c_CNT_ONE;
                    default: w_free_count_nxt = r_free_count;
                endcase
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_INIT;
            r_head       <= '0;
            r_tail       <= '0;
            r_free_count <= '0;
            r_init_done  <= 1'b0;
            r_rel_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_head       <= w_head_nxt;
            r_tail       <= w_tail_nxt;
            r_free_count <= w_free_count_nxt;
            r_init_done  <= w_init_done_nxt;
            r_rel_err    <= w_rel_err_nxt;
        end
    end

    // Storage is not reset; the INIT sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (rstn && w_mem_we) begin
            r_fl_mem[r_tail] <= w_mem_wdata;
        end
    end

    assign fl_if.in_ready    = w_in_ready;
    assign fl_if.buf_wr_en   = w_alloc;
    assign fl_if.buf_wr_addr = (r_state == ST_READY) ? r_fl_mem[r_head] : '0;

    assign init_done    = r_init_done;
    assign free_count   = r_free_count;
    assign almost_empty = (r_free_count <= c_LOW_WM);
    assign rel_err      = r_rel_err;

endmodule
`default_nettype wire

// File: tb/tb_pkt_buffer_fl_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_buffer_fl_ctrl
// Brief    : Randomized and directed bench for pkt_buffer_fl_ctrl against a
//            queue-based free-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_buffer_fl_ctrl;

    localparam int c_AW    = 12;
    localparam int c_DEPTH = 4096;
    localparam int c_LOWWM = 16;

    logic               clk;
    logic               rstn;
    logic               init_done;
    logic [c_AW:0]      free_count;
    logic               almost_empty;
    logic               rel_err;

    pkt_buffer_fl_ctrl_if #(.ADDR_WIDTH(c_AW)) fl_if ();

    pkt_buffer_fl_ctrl #(
        .ADDR_WIDTH (c_AW),
        .DEPTH      (c_DEPTH),
        .LOW_WM     (c_LOWWM)
    ) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .fl_if        (fl_if),
        .init_done    (init_done),
        .free_count   (free_count),
        .almost_empty (almost_empty),
        .rel_err      (rel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: free slots in hand-out order, plus slots held by the caller.
    int fq[$];
    int out_q[$];
    bit m_ready   = 1'b0;
    int m_init    = 0;
    bit m_rel_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        out_q.delete();
        m_ready   = 1'b0;
        m_init    = 0;
        m_rel_err = 1'b0;
    endtask

    task automatic step(input bit iv, input bit rv, input int ra);
        bit exp_ready;
        bit alloc;
        bit acc;
        int exp_fc;
        fl_if.in_valid  = iv;
        fl_if.rel_valid = rv;
        fl_if.rel_addr  = c_AW'(ra);
        @(negedge clk);
        exp_ready = m_ready && (fq.size() != 0);
        exp_fc    = m_ready ? fq.size() : m_init;
        check("in_ready",     fl_if.in_ready,  exp_ready);
        check("buf_wr_en",    fl_if.buf_wr_en, iv && exp_ready);
        if (!m_ready)
            check("addr_idle", fl_if.buf_wr_addr, 0);
        else if (exp_ready)
            check("buf_wr_addr", fl_if.buf_wr_addr, fq[0]);
        check("init_done",    init_done,    m_ready);
        check("free_count",   free_count,   exp_fc);
        check("almost_empty", almost_empty, exp_fc <= c_LOWWM);
        check("rel_err",      rel_err,      m_rel_err);
        @(posedge clk);
        if (!rstn) begin
            model_reset();
        end else if (!m_ready) begin
            m_rel_err = rv;
            m_init++;
            if (m_init == c_DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < c_DEPTH; i++) fq.push_back(i);
            end
        end else begin
            alloc     = iv && exp_ready;
            acc       = rv && ((fq.size() < c_DEPTH) || alloc);
            m_rel_err = rv && !acc;
            if (alloc) out_q.push_back(fq.pop_front());
            if (acc) fq.push_back(ra % c_DEPTH);
        end
        #1;
    endtask

    task automatic pick(output bit ok, output int a);
        int idx;
        ok = 1'b0;
        a  = 0;
        if (out_q.size() != 0) begin
            idx = $urandom_range(0, out_q.size() - 1);
            a   = out_q[idx];
            out_q.delete(idx);
            ok  = 1'b1;
        end
    endtask

    task automatic take(input int a);
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] == a) begin
                out_q.delete(i);
                break;
            end
        end
    endtask

    task automatic run_init(input bit noisy);
        for (int i = 0; i < c_DEPTH; i++)
            step(noisy ? 1'($urandom_range(0, 1)) : 1'b0,
                 noisy ? ((i < 4) || ($urandom_range(0, 7) == 0)) : 1'b0,
                 int'($urandom_range(0, c_DEPTH - 1)));
    endtask

    task automatic three_beats(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_addr"}, fl_if.buf_wr_addr, k);
            step(1'b1, 1'b0, 0);
        end
        check({tag, "_fc"}, free_count, c_DEPTH - 3);
    endtask

    initial begin
        bit ok;
        bit iv;
        bit rv;
        int a;

        rstn            = 1'b0;
        fl_if.in_valid  = 1'b0;
        fl_if.rel_valid = 1'b0;
        fl_if.rel_addr  = '0;
        @(posedge clk);
        #1;
        model_reset();
        repeat (3) step(1'b1, 1'b1, 9);
        check("rst_fc",   free_count,   0);
        check("rst_ae",   almost_empty, 1);
        check("rst_done", init_done,    0);

        // Initialisation with releases arriving (all dropped)
        rstn = 1'b1;
        run_init(1'b1);
        check("init_done_up", init_done,      1);
        check("init_fc",      free_count,     c_DEPTH);
        check("init_ready",   fl_if.in_ready, 1);

        // Release while full is dropped with a one-cycle error pulse
        step(1'b0, 1'b1, 123);
        check("full_rel_err", rel_err,    1);
        check("full_rel_fc",  free_count, c_DEPTH);
        step(1'b0, 1'b0, 0);
        check("full_rel_err_clr", rel_err, 0);

        three_beats("first");

        // Random mixed traffic
        for (int n = 0; n < 2500; n++) begin
            iv = ($urandom_range(0, 99) < 60);
            rv = 1'b0;
            a  = 0;
            if ($urandom_range(0, 1) == 1) begin
                pick(ok, a);
                rv = ok;
            end
            if (!rv && fq.size() == c_DEPTH && $urandom_range(0, 3) == 0) begin
                rv = 1'b1;
                a  = int'($urandom_range(0, c_DEPTH - 1));
            end
            step(iv, rv, a);
        end

        // Drain to empty, then release slot 7 into the empty list
        while (fq.size() != 0) step(1'b1, 1'b0, 0);
        check("empty_ready", fl_if.in_ready, 0);
        check("empty_fc",    free_count,     0);
        step(1'b1, 1'b0, 0);
        take(7);
        step(1'b1, 1'b1, 7);
        check("refill_ready", fl_if.in_ready,    1);
        check("refill_addr",  fl_if.buf_wr_addr, 7);

        // Same-cycle alloc and release at free_count = 100
        take(5);
        repeat (99) begin
            pick(ok, a);
            step(1'b0, ok, a);
        end
        check("fc_100", free_count, 100);
        step(1'b1, 1'b1, 5);
        check("fc_100_kept", free_count, 100);
        repeat (99) step(1'b1, 1'b0, 0);
        check("ret_addr_5", fl_if.buf_wr_addr, 5);
        check("ret_fc_1",   free_count,        1);

        // Reset mid-traffic at free_count = 50
        repeat (49) begin
            pick(ok, a);
            step(1'b0, ok, a);
        end
        check("fc_50", free_count, 50);
        rstn = 1'b0;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 3);
        check("mid_rst_fc",    free_count,        0);
        check("mid_rst_done",  init_done,         0);
        check("mid_rst_ready", fl_if.in_ready,    0);
        check("mid_rst_addr",  fl_if.buf_wr_addr, 0);
        check("mid_rst_ae",    almost_empty,      1);
        rstn = 1'b1;
        run_init(1'b0);
        check("reinit_done", init_done,  1);
        check("reinit_fc",   free_count, c_DEPTH);
        three_beats("reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
